// File: rtl/ss_sync_fifo_pkg.sv
// ss_sync_fifo_pkg: default widths and depth helper shared by the FIFO slice
package ss_sync_fifo_pkg;
  localparam int bw_d_def = 8;
  localparam int bw_a_def = 5;
  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/ss_sync_fifo_if.sv
// ss_sync_fifo_if: write/read handshake bundle of the show-ahead FIFO
interface ss_sync_fifo_if
  import ss_sync_fifo_pkg::*;
#(
  parameter int Bw_d = bw_d_def
) ();
  logic [Bw_d-1:0] wr_di;
  logic            wr_en;
  logic            wr_rdy;
  logic            rd_en;
  logic            rd_rdy;
  logic [Bw_d-1:0] rd_do;
  modport slave  (input  wr_di, wr_en, rd_en, output wr_rdy, rd_rdy, rd_do);
  modport master (output wr_di, wr_en, rd_en, input  wr_rdy, rd_rdy, rd_do);
endinterface

// File: rtl/ss_sync_fifo_mem.sv
// ss_sync_fifo_mem: storage array with one synchronous write and one asynchronous read port
module ss_sync_fifo_mem
  import ss_sync_fifo_pkg::*;
#(
  parameter int Bw_d = bw_d_def,
  parameter int Bw_a = bw_a_def
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [Bw_a-1:0] wa_i,
  input  logic [Bw_d-1:0] wd_i,
  input  logic [Bw_a-1:0] ra_i,
  output logic [Bw_d-1:0] rd_o
);
  logic [Bw_d-1:0] mem_q [fifo_depth(Bw_a)];
  // write port; contents deliberately not reset
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wa_i] <= wd_i;
  end
  assign rd_o = mem_q[ra_i];
endmodule

// File: rtl/ss_sync_fifo.sv
// ss_sync_fifo: single-clock first-word fall-through FIFO with ready/enable handshakes
module ss_sync_fifo
  import ss_sync_fifo_pkg::*;
#(
  parameter int Bw_d = bw_d_def,
  parameter int Bw_a = bw_a_def
) (
  input  logic          clk,
  input  logic          reset,
  ss_sync_fifo_if.slave f
);
  localparam logic [Bw_a:0] depth = (Bw_a+1)'(fifo_depth(Bw_a));
  logic [Bw_a-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Bw_a:0]   cnt_q, cnt_d;
  logic            wr_ok, rd_ok;
  logic [Bw_d-1:0] mem_rd;
  assign f.wr_rdy = cnt_q != depth;
  assign f.rd_rdy = cnt_q != '0;
  assign f.rd_do  = f.rd_rdy ? mem_rd : '0;
  // accepted transfers advance pointers; count moves only on a lone write or lone read
  always_comb begin
    wr_ok    = f.wr_en && f.wr_rdy;
    rd_ok    = f.rd_en && f.rd_rdy;
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = (wr_ok && !rd_ok) ? cnt_q + 1'b1 : (rd_ok && !wr_ok) ? cnt_q - 1'b1 : cnt_q;
  end
  // pointer and occupancy registers; reset empties the FIFO at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
  ss_sync_fifo_mem #(.Bw_d(Bw_d), .Bw_a(Bw_a)) u_mem (
    .clk  (clk),
    .we_i (wr_ok),
    .wa_i (wr_ptr_q),
    .wd_i (f.wr_di),
    .ra_i (rd_ptr_q),
    .rd_o (mem_rd)
  );
endmodule

// File: tb/tb_ss_sync_fifo.sv
// tb_ss_sync_fifo: scoreboard bench for the show-ahead FIFO
module tb_ss_sync_fifo;
  logic clk = 0;
  logic reset = 0;
  int   total = 0;
  int   bad = 0;
  logic [7:0] sb [$];
  ss_sync_fifo_if #(.Bw_d(8)) f ();
  ss_sync_fifo #(.Bw_d(8), .Bw_a(5)) dut (.clk(clk), .reset(reset), .f(f));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // one clock of stimulus: check visible state against the scoreboard, then apply the edge
  task automatic step(input logic we, input logic [7:0] wd, input logic re, input string tag);
    bit wacc, racc;
    f.wr_en = we;
    f.wr_di = wd;
    f.rd_en = re;
    #1;
    chk({tag, ".wr_rdy"}, 32'(f.wr_rdy), 32'(sb.size() != 32));
    chk({tag, ".rd_rdy"}, 32'(f.rd_rdy), 32'(sb.size() != 0));
    chk({tag, ".rd_do"}, 32'(f.rd_do), sb.size() != 0 ? 32'(sb[0]) : 32'd0);
    wacc = we && sb.size() != 32;
    racc = re && sb.size() != 0;
    @(posedge clk);
    #1;
    if (racc) void'(sb.pop_front());
    if (wacc) sb.push_back(wd);
    f.wr_en = 0;
    f.rd_en = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    f.wr_en = 0;
    f.rd_en = 0;
    f.wr_di = 0;
    #12;
    chk("rst.wr_rdy", 32'(f.wr_rdy), 1);
    chk("rst.rd_rdy", 32'(f.rd_rdy), 0);
    chk("rst.rd_do", 32'(f.rd_do), 0);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    step(0, 8'h00, 1, "underflow");
    step(0, 8'h00, 0, "after_uf");
    step(1, 8'hA5, 0, "single_wr");
    chk("single.rd_do", 32'(f.rd_do), 32'hA5);
    step(0, 8'h00, 1, "single_rd");
    step(0, 8'h00, 0, "single_empty");
    for (int i = 0; i < 32; i++) step(1, 8'(i), 0, "fill");
    chk("full.wr_rdy", 32'(f.wr_rdy), 0);
    step(1, 8'hFF, 0, "overflow");
    for (int i = 0; i < 32; i++) begin
      chk("drain.order", 32'(f.rd_do), 32'(i));
      step(0, 8'h00, 1, "drain");
    end
    step(0, 8'h00, 0, "drained");
    for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0, "pre5");
    for (int i = 0; i < 4; i++) step(1, 8'(8'h50 + i), 1, "both5");
    chk("both5.size", 32'(sb.size()), 5);
    while (sb.size() < 32) step(1, 8'(8'h60 + sb.size()), 0, "refill");
    step(1, 8'hEE, 1, "both_full");
    chk("both_full.wr_rdy", 32'(f.wr_rdy), 1);
    while (sb.size() != 0) step(0, 8'h00, 1, "drain2");
    step(1, 8'h77, 1, "both_empty");
    chk("both_empty.rd_rdy", 32'(f.rd_rdy), 1);
    chk("both_empty.rd_do", 32'(f.rd_do), 32'h77);
    while (sb.size() < 16) step(1, 8'($urandom), 0, "prewrap");
    for (int i = 0; i < 200; i++)
      step(sb.size() < 31 && $urandom_range(0, 1) == 1, 8'($urandom),
           sb.size() > 1 && $urandom_range(0, 1) == 1, "wrap");
    while (sb.size() != 0) step(0, 8'h00, 1, "drain3");
    for (int i = 0; i < 10; i++) step(1, 8'(8'h90 + i), 0, "pre_rst");
    @(negedge clk);
    reset = 0;
    #1;
    chk("async_rst.rd_rdy", 32'(f.rd_rdy), 0);
    chk("async_rst.wr_rdy", 32'(f.wr_rdy), 1);
    sb.delete();
    #1;
    reset = 1;
    for (int i = 0; i < 3; i++) step(1, 8'(8'hC0 + i), 0, "post_rst_wr");
    while (sb.size() != 0) step(0, 8'h00, 1, "post_rst_rd");
    step(0, 8'h00, 0, "final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
